// File: rtl/instruction_decoder_pkg.sv
// Shared opcode and FSM state definitions for the fetch/decode pipeline.
// Opcodes are a fixed 8-bit field regardless of datapath width.
package instruction_decoder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXECUTE,
        SHIFT,
        DONE,
        HALT
    } state_t;

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_LDI  = 8'h01,
        OP_ADDI = 8'h02,
        OP_SUBI = 8'h03,
        OP_ANDI = 8'h04,
        OP_ORI  = 8'h05,
        OP_XORI = 8'h06,
        OP_STA  = 8'h07,
        OP_LDA  = 8'h08,
        OP_ADDR = 8'h09,
        OP_SHL  = 8'h0A,
        OP_SHR  = 8'h0B,
        OP_HALT = 8'hFF
    } opcode_t;

    function automatic logic op_defined(input logic [7:0] op);
        return (op <= OP_SHR) || (op == OP_HALT);
    endfunction

    // Every opcode that writes the accumulator also rewrites both flags.
    function automatic logic op_writes_acc(input logic [7:0] op);
        case (op)
            OP_LDI, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI,
            OP_XORI, OP_LDA, OP_ADDR: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instruction_decoder_alu.sv
// Combinational ALU: one-step result, carry and zero for the current opcode.
// Shift opcodes produce a single-bit shift; the FSM iterates it.
module decoder_alu
    import instruction_decoder_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] operand_i,
    input  logic [7:0]   opcode_i,
    output logic [W-1:0] result_o,
    output logic         carry_o,
    output logic         zero_o
);

    logic [W:0] sum;

    always_comb begin
        result_o = acc_i;
        carry_o  = 1'b0;
        sum      = {1'b0, acc_i} + {1'b0, operand_i};
        case (opcode_i)
            OP_LDI, OP_LDA:   result_o = operand_i;
            OP_ADDI, OP_ADDR: begin
                result_o = sum[W-1:0];
                carry_o  = sum[W];
            end
            OP_SUBI: begin
                result_o = acc_i - operand_i;
                carry_o  = (operand_i > acc_i);
            end
            OP_ANDI: result_o = acc_i & operand_i;
            OP_ORI:  result_o = acc_i | operand_i;
            OP_XORI: result_o = acc_i ^ operand_i;
            OP_SHL: begin
                result_o = {acc_i[W-2:0], 1'b0};
                carry_o  = acc_i[W-1];
            end
            OP_SHR: begin
                result_o = {1'b0, acc_i[W-1:1]};
                carry_o  = acc_i[0];
            end
            default: result_o = acc_i;
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/instruction_decoder.sv
// Accumulator-machine decode/execute FSM with local register file.
// 'byte' is a reserved word, so the datapath width parameter is byte_w.
module instruction_decoder
    import instruction_decoder_pkg::*;
#(
    parameter int unsigned byte_w    = 8,
    parameter int unsigned width_in  = 2 * byte_w,
    parameter int unsigned reg_count = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_from_fetch,
    input  logic [width_in-1:0] data_from_fetch,
    output logic                ready_for_fetch,
    output logic [byte_w-1:0]   acc_out,
    output logic                result_valid,
    output logic                carry_flag,
    output logic                zero_flag,
    output logic                illegal_opcode,
    output logic                halted
);

    state_t              state_q, state_d;
    logic [width_in-1:0] instr_q, instr_d;
    logic [byte_w-1:0]   acc_q, acc_d;
    logic [byte_w-1:0]   regs_q [reg_count];
    logic [byte_w-1:0]   regs_d [reg_count];
    logic                carry_q, carry_d, zero_q, zero_d;
    logic                illegal_q, illegal_d, halted_q, halted_d;
    logic                ready_q, ready_d, valid_q, valid_d;
    logic [2:0]          cnt_q, cnt_d;

    logic [7:0]          opcode;
    logic [byte_w-1:0]   operand, alu_operand, alu_result;
    logic [1:0]          ridx;
    logic                alu_carry, alu_zero;

    assign opcode      = instr_q[width_in-1 -: 8];
    assign operand     = instr_q[byte_w-1:0];
    assign ridx        = operand[1:0];
    assign alu_operand = (opcode == OP_LDA || opcode == OP_ADDR) ? regs_q[ridx] : operand;

    decoder_alu #(.W(byte_w)) u_alu (
        .acc_i     (acc_q),
        .operand_i (alu_operand),
        .opcode_i  (opcode),
        .result_o  (alu_result),
        .carry_o   (alu_carry),
        .zero_o    (alu_zero)
    );

    // ready/valid are registered: ready rises one cycle after re-entering IDLE,
    // and the retire pulse appears the cycle after DONE.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        acc_d     = acc_q;
        regs_d    = regs_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        halted_d  = halted_q;
        cnt_d     = cnt_q;
        ready_d   = 1'b0;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (start_from_fetch && ready_q) begin
                    instr_d = data_from_fetch;
                    state_d = DECODE;
                    ready_d = 1'b0;
                end
            end
            DECODE: begin
                if (opcode == OP_SHL || opcode == OP_SHR) begin
                    cnt_d   = operand[2:0];
                    state_d = SHIFT;
                end else if (opcode == OP_HALT) begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else begin
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                if (!op_defined(opcode)) begin
                    illegal_d = 1'b1;
                end else if (opcode == OP_STA) begin
                    regs_d[ridx] = acc_q;
                end else if (op_writes_acc(opcode)) begin
                    acc_d   = alu_result;
                    carry_d = alu_carry;
                    zero_d  = alu_zero;
                end
                state_d = DONE;
            end
            SHIFT: begin
                if (cnt_q == 3'd0) begin
                    zero_d  = (acc_q == '0);
                    state_d = DONE;
                end else begin
                    acc_d   = alu_result;
                    carry_d = alu_carry;
                    zero_d  = alu_zero;
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            DONE: begin
                valid_d = 1'b1;
                state_d = IDLE;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            acc_q     <= '0;
            regs_q    <= '{default: '0};
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            acc_q     <= acc_d;
            regs_q    <= regs_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ready_for_fetch = ready_q;
    assign acc_out         = acc_q;
    assign result_valid    = valid_q;
    assign carry_flag      = carry_q;
    assign zero_flag       = zero_q;
    assign illegal_opcode  = illegal_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: directed scenarios plus a
// randomized program checked against an instruction-level reference model.
module tb_instruction_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data = '0;
    logic        ready_for_fetch, result_valid, carry_flag, zero_flag, illegal_opcode, halted;
    logic [7:0]  acc_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_acc;
    logic       m_c, m_z, m_ill;
    logic [7:0] m_regs [4];

    instruction_decoder #(.byte_w(8), .width_in(16), .reg_count(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .start_from_fetch (start),
        .data_from_fetch  (data),
        .ready_for_fetch  (ready_for_fetch),
        .acc_out          (acc_out),
        .result_valid     (result_valid),
        .carry_flag       (carry_flag),
        .zero_flag        (zero_flag),
        .illegal_opcode   (illegal_opcode),
        .halted           (halted)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_acc = '0; m_c = 1'b0; m_z = 1'b0; m_ill = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
    endtask

    // Applies one instruction to the model; returns expected accept-to-retire latency.
    function automatic int model_exec(input logic [7:0] opc, input logic [7:0] opd);
        int s;
        int n;
        n = 0;
        case (opc)
            8'h00: ;
            8'h01: begin m_acc = opd; m_c = 1'b0; end
            8'h02: begin s = int'(m_acc) + int'(opd); m_c = (s > 255); m_acc = 8'(s % 256); end
            8'h03: begin m_c = (opd > m_acc); s = (int'(m_acc) + 256 - int'(opd)) % 256; m_acc = 8'(s); end
            8'h04: begin m_acc = m_acc & opd; m_c = 1'b0; end
            8'h05: begin m_acc = m_acc | opd; m_c = 1'b0; end
            8'h06: begin m_acc = m_acc ^ opd; m_c = 1'b0; end
            8'h07: m_regs[opd % 4] = m_acc;
            8'h08: begin m_acc = m_regs[opd % 4]; m_c = 1'b0; end
            8'h09: begin s = int'(m_acc) + int'(m_regs[opd % 4]); m_c = (s > 255); m_acc = 8'(s % 256); end
            8'h0A, 8'h0B: begin
                n = int'(opd % 8);
                for (int i = 0; i < n; i++) begin
                    if (opc == 8'h0A) begin
                        m_c = (m_acc >= 128);
                        m_acc = 8'((int'(m_acc) * 2) % 256);
                    end else begin
                        m_c = ((m_acc % 2) != 0);
                        m_acc = m_acc / 2;
                    end
                end
            end
            default: m_ill = 1'b1;
        endcase
        if (opc != 8'h00 && opc != 8'h07 && (opc <= 8'h0B))
            m_z = (m_acc == 0);
        return 4 + n;
    endfunction

    // Issues one instruction; lat = cycles from accept to result_valid (-1 if never ready).
    task automatic exec_instr(input logic [7:0] opc, input logic [7:0] opd, output int lat);
        int n = 0;
        while (ready_for_fetch !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (ready_for_fetch !== 1'b1) begin lat = -1; return; end
        start = 1'b1;
        data  = {opc, opd};
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (result_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        data  = 16'h0155;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ready_for_fetch !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready_for_fetch);
        else n_pass++;
        n_checks++;
        if ({acc_out, carry_flag, zero_flag, illegal_opcode, halted, result_valid} !== 13'h0)
            $display("FAIL reset_state: got acc=%h c%b z%b ill%b h%b v%b expected all 0",
                     acc_out, carry_flag, zero_flag, illegal_opcode, halted, result_valid);
        else n_pass++;
        start = 1'b0;
        reset = 1'b1;
        model_reset();
        begin
            int pulses = 0;
            repeat (8) begin @(negedge clk); if (result_valid === 1'b1) pulses++; end
            n_checks++;
            if (pulses != 0 || acc_out !== 8'h00)
                $display("FAIL reset_no_accept: got pulses=%0d acc=%h expected 0 and 00", pulses, acc_out);
            else n_pass++;
        end
    endtask

    task automatic test_add_carry();
        int lat;
        exec_instr(8'h01, 8'h05, lat);
        void'(model_exec(8'h01, 8'h05));
        n_checks++;
        if (lat != 4) $display("FAIL ldi_latency: got %0d expected 4", lat);
        else n_pass++;
        exec_instr(8'h02, 8'hFB, lat);
        void'(model_exec(8'h02, 8'hFB));
        n_checks++;
        if (lat != 4) $display("FAIL addi_latency: got %0d expected 4", lat);
        else n_pass++;
        n_checks++;
        if ({acc_out, carry_flag, zero_flag} !== {8'h00, 1'b1, 1'b1})
            $display("FAIL addi_wrap: got acc=%h c=%b z=%b expected 00 1 1", acc_out, carry_flag, zero_flag);
        else n_pass++;
    endtask

    task automatic test_shift();
        int lat;
        exec_instr(8'h01, 8'h81, lat);
        void'(model_exec(8'h01, 8'h81));
        exec_instr(8'h0A, 8'h03, lat);
        void'(model_exec(8'h0A, 8'h03));
        n_checks++;
        if (lat != 7) $display("FAIL shl3_latency: got %0d expected 7", lat);
        else n_pass++;
        n_checks++;
        if ({acc_out, carry_flag, zero_flag} !== {8'h08, 1'b0, 1'b0})
            $display("FAIL shl3_result: got acc=%h c=%b z=%b expected 08 0 0", acc_out, carry_flag, zero_flag);
        else n_pass++;
        exec_instr(8'h0A, 8'h00, lat);
        void'(model_exec(8'h0A, 8'h00));
        n_checks++;
        if (lat != 4 || acc_out !== 8'h08 || carry_flag !== 1'b0)
            $display("FAIL shl0: got lat=%0d acc=%h c=%b expected 4 08 0", lat, acc_out, carry_flag);
        else n_pass++;
    endtask

    task automatic test_regs();
        int lat;
        exec_instr(8'h01, 8'h10, lat); void'(model_exec(8'h01, 8'h10));
        exec_instr(8'h07, 8'h02, lat); void'(model_exec(8'h07, 8'h02));
        exec_instr(8'h01, 8'h00, lat); void'(model_exec(8'h01, 8'h00));
        exec_instr(8'h09, 8'h02, lat); void'(model_exec(8'h09, 8'h02));
        n_checks++;
        if ({acc_out, carry_flag, zero_flag} !== {8'h10, 1'b0, 1'b0})
            $display("FAIL sta_addr: got acc=%h c=%b z=%b expected 10 0 0", acc_out, carry_flag, zero_flag);
        else n_pass++;
    endtask

    task automatic test_illegal();
        int lat;
        exec_instr(8'h3C, 8'h00, lat);
        void'(model_exec(8'h3C, 8'h00));
        n_checks++;
        if (lat != 4 || illegal_opcode !== 1'b1 || acc_out !== m_acc)
            $display("FAIL illegal: got lat=%0d ill=%b acc=%h expected 4 1 %h", lat, illegal_opcode, acc_out, m_acc);
        else n_pass++;
        exec_instr(8'h01, 8'h01, lat);
        void'(model_exec(8'h01, 8'h01));
        n_checks++;
        if (lat != 4 || acc_out !== 8'h01 || illegal_opcode !== 1'b1)
            $display("FAIL after_illegal: got lat=%0d acc=%h ill=%b expected 4 01 1", lat, acc_out, illegal_opcode);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat, exp_lat;
        logic [7:0] opc, opd;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) < 9) opc = 8'($urandom_range(0, 11));
            else opc = 8'($urandom_range(12, 254));
            opd = 8'($urandom);
            exp_lat = model_exec(opc, opd);
            exec_instr(opc, opd, lat);
            n_checks++;
            if (lat != exp_lat || {acc_out, carry_flag, zero_flag, illegal_opcode} !== {m_acc, m_c, m_z, m_ill})
                $display("FAIL random[%0d] op=%h/%h: got lat=%0d acc=%h c%b z%b i%b expected lat=%0d acc=%h c%b z%b i%b",
                         k, opc, opd, lat, acc_out, carry_flag, zero_flag, illegal_opcode,
                         exp_lat, m_acc, m_c, m_z, m_ill);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int windows = 0;
        int pulses  = 0;
        int n = 0;
        exec_instr(8'h01, 8'h00, lat);
        void'(model_exec(8'h01, 8'h00));
        while (ready_for_fetch !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        start = 1'b1;
        data  = 16'h0201;
        for (int i = 0; i < 50; i++) begin
            if (ready_for_fetch === 1'b1) windows++;
            if (result_valid === 1'b1) begin pulses++; void'(model_exec(8'h02, 8'h01)); end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (10) begin
            if (result_valid === 1'b1) begin pulses++; void'(model_exec(8'h02, 8'h01)); end
            @(negedge clk);
        end
        n_checks++;
        if (windows != 10 || pulses != 10)
            $display("FAIL held_start: got windows=%0d pulses=%0d expected 10 10", windows, pulses);
        else n_pass++;
        n_checks++;
        if (acc_out !== m_acc) $display("FAIL held_start_acc: got %h expected %h", acc_out, m_acc);
        else n_pass++;
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        int pulses = 0;
        int n = 0;
        exec_instr(8'h01, 8'h81, lat);
        while (ready_for_fetch !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        start = 1'b1;
        data  = 16'h0A07;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        n_checks++;
        if (ready_for_fetch !== 1'b1 || acc_out !== 8'h00 || result_valid !== 1'b0)
            $display("FAIL mid_shift_reset: got ready=%b acc=%h v=%b expected 1 00 0",
                     ready_for_fetch, acc_out, result_valid);
        else n_pass++;
        repeat (12) begin @(negedge clk); if (result_valid === 1'b1) pulses++; end
        n_checks++;
        if (pulses != 0 || acc_out !== 8'h00)
            $display("FAIL mid_shift_retire: got pulses=%0d acc=%h expected 0 00", pulses, acc_out);
        else n_pass++;
    endtask

    task automatic test_halt();
        int lat;
        int bad = 0;
        int n = 0;
        exec_instr(8'h01, 8'h5A, lat);
        void'(model_exec(8'h01, 8'h5A));
        while (ready_for_fetch !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        start = 1'b1;
        data  = 16'hFF00;
        @(negedge clk);
        data  = 16'h0177;
        @(negedge clk);
        repeat (20) begin
            @(negedge clk);
            if (halted !== 1'b1 || ready_for_fetch !== 1'b0 || result_valid !== 1'b0 || acc_out !== m_acc) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL halt_hold: got %0d bad cycles expected 0", bad);
        else n_pass++;
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        n_checks++;
        if (halted !== 1'b0 || ready_for_fetch !== 1'b1)
            $display("FAIL halt_reset: got halted=%b ready=%b expected 0 1", halted, ready_for_fetch);
        else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add_carry();
        test_shift();
        test_regs();
        test_illegal();
        test_random();
        test_back_to_back();
        test_reset_mid_shift();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_decoder.md
INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 The module SHALL have parameter byte, default 8, giving the datapath byte width.
REQ-002 The module SHALL have parameter width_in, default 2*byte, giving the instruction word width as {opcode, operand}.
REQ-003 The module SHALL have parameter reg_count, default 4, giving the number of general registers.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset, input, 1, a synchronous active-low reset.
REQ-006 The module SHALL have port start_from_fetch, input, 1, indicating that the instruction word is valid.
REQ-007 The module SHALL have port data_from_fetch, input, width_in, the instruction: [15:8] opcode, [7:0] operand.
REQ-008 The module SHALL have port ready_for_fetch, output, 1, high when a new instruction can be accepted.
REQ-009 The module SHALL have port acc_out, output, byte, the current accumulator value.
REQ-010 The module SHALL have port result_valid, output, 1, a one-cycle pulse when an instruction retires.
REQ-011 The module SHALL have port carry_flag, output, 1, the carry/borrow/shift-out bit of the last ALU or shift operation.
REQ-012 The module SHALL have port zero_flag, output, 1, high when the accumulator is 0 after the last ALU, load or shift operation.
REQ-013 The module SHALL have port illegal_opcode, output, 1, sticky, set when an undefined opcode is received.
REQ-014 The module SHALL have port halted, output, 1, high after a HALT instruction.

Function
REQ-015 The FSM SHALL use states IDLE, DECODE, EXECUTE, SHIFT, DONE and HALT.
REQ-016 ready_for_fetch SHALL be 1 only in IDLE.
REQ-017 A word SHALL be accepted only on an edge where start_from_fetch=1 and ready_for_fetch=1; the word is captured and the FSM goes to DECODE.
REQ-018 start_from_fetch SHALL be ignored in every state other than IDLE.
REQ-019 DECODE SHALL last one cycle and go to SHIFT for SHL/SHR, HALT for 0xFF, and EXECUTE otherwise.
REQ-020 EXECUTE SHALL last one cycle, update the accumulator, registers and flags, and go to DONE.
REQ-021 DONE SHALL drive result_valid=1 for exactly one cycle and return to IDLE.
REQ-022 For an accept at edge T, result_valid SHALL be high in the cycle after edge T+3 and ready_for_fetch SHALL be high again after edge T+4 (non-shift instructions).
REQ-023 The opcodes SHALL be:
- 0x00 NOP
- 0x01 LDI: acc=op
- 0x02 ADDI
- 0x03 SUBI
- 0x04 ANDI
- 0x05 ORI
- 0x06 XORI
- 0x07 STA: reg[op[1:0]]=acc
- 0x08 LDA: acc=reg[op[1:0]]
- 0x09 ADDR: acc+=reg[op[1:0]]
- 0x0A SHL
- 0x0B SHR
- 0xFF HALT
REQ-024 ADD operations SHALL compute a byte+1-bit sum, set carry to bit 8 and keep the low byte; SUBI SHALL set carry=1 when op>acc (borrow), with the result wrapping modulo 256.
REQ-025 Logic operations, LDI and LDA SHALL clear carry; NOP and STA SHALL leave both flags unchanged; zero_flag SHALL be updated by every operation that writes acc.
REQ-026 SHIFT SHALL load a counter with op[2:0] and shift acc by 1 bit per cycle, setting carry to the bit shifted out, until the counter reaches 0, then go to DONE.
REQ-027 A shift count of 0 SHALL go directly to DONE with acc and carry unchanged and zero_flag updated.
REQ-028 An undefined opcode SHALL set illegal_opcode (sticky until reset), leave acc, registers and flags unchanged, and still retire through DONE with the result_valid pulse.
REQ-029 In HALT, halted=1 and ready_for_fetch=0 SHALL hold until reset, and no result_valid pulse SHALL be produced.

Reset
REQ-030 reset=0 sampled at an edge SHALL force IDLE, acc=0, all registers=0, and carry_flag, zero_flag, illegal_opcode, halted and result_valid=0.
REQ-031 After reset, ready_for_fetch SHALL be 1 (IDLE), including when reset is asserted mid-instruction or mid-shift, and the interrupted instruction SHALL not retire.
REQ-032 While reset=0, an asserted start_from_fetch SHALL NOT be accepted.

Structure
REQ-033 The opcode constants and state encodings SHALL reside in a shared package used by both the fetch state machine and this block.
REQ-034 There SHALL be one sub-module, decoder_alu: a combinational unit taking acc, operand and opcode and producing result, carry and zero.
REQ-035 The register file SHALL be held locally as reg_count x byte.

Verification
REQ-036 Reset, then LDI 0x05 and ADDI 0xFB -> acc=0x00, carry=1, zero=1, with result_valid 4 cycles after each accept.
REQ-037 LDI 0x81, SHL 0x03 -> acc=0x08, carry=0 (last bit out), and result_valid 3 cycles later than a non-shift instruction; SHL 0x00 -> acc unchanged.
REQ-038 LDI 0x10, STA 0x02, LDI 0x00, ADDR 0x02 -> acc=0x10, zero=0.
REQ-039 Opcode 0x3C -> illegal_opcode=1 and stays 1, acc unchanged, result_valid pulsed; a following LDI 0x01 works normally.
REQ-040 Holding start_from_fetch=1 continuously -> exactly one accept per ready window; and HALT -> halted=1, ready_for_fetch=0 for 20 cycles until reset.
REQ-041 reset=0 during SHIFT state -> next cycle IDLE, acc=0, no result_valid pulse.
